// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain stage with 2-entry skid buffer
//
// Pulls words out of the upstream FIFO and re-presents them as a valid/ready
// stream. It sustains one word per cycle while m_ready stays high.
//
// Optional feature macro: FIFO_RD_STATS_EN (adds xfer_count / stall_count).
//
// Ports:
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous active-low reset (0 = reset)
//   fifo_empty   in   FIFO empty flag
//   fifo_wr      in   copy of the FIFO write strobe (write wins over read)
//   fifo_dout    in   FIFO registered read data, valid the cycle after a read
//   fifo_rd      out  read request to the FIFO (combinational, depends on m_ready)
//   m_data       out  stream data (skid head entry)
//   m_valid      out  stream valid
//   m_ready      in   downstream accept
//   xfer_count   out  accepted beats, wrapping    (FIFO_RD_STATS_EN only)
//   stall_count  out  valid-without-ready cycles, saturating (FIFO_RD_STATS_EN only)

module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_wr,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  logic [1:0]       occ_q, occ_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;   // head entry
  logic [WIDTH-1:0] buf1_q, buf1_d;   // second entry
  logic             pop;
  logic             rd_acc;
  logic [2:0]       credit;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0_q;

  always_comb begin
    pop    = m_valid && m_ready;
    // Words already owned by this stage (buffered + in flight), minus the one
    // leaving this cycle. Keeping this below 2 guarantees a capture never
    // lands in a full buffer.
    credit = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    fifo_rd = rst && !fifo_empty && (credit < 3'd2);
    // The FIFO drops a read that coincides with a write; retry naturally
    // happens next cycle because the credit is unchanged.
    rd_acc = fifo_rd && !fifo_empty && !fifo_wr;
  end

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    pend_d = rd_acc;
    case ({pend_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_dout;
        else               buf1_d = fifo_dout;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Head leaves and a new word arrives: it goes behind whatever remains.
        if (occ_q == 2'd1) begin
          buf0_d = fifo_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= 2'd0;
      pend_q <= 1'b0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= pend_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    xfer_count_d  = xfer_count_q;
    stall_count_d = stall_count_q;
    if (pop) xfer_count_d = xfer_count_q + CNT_W'(1);
    if (m_valid && !m_ready && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      xfer_count_q  <= xfer_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign xfer_count  = xfer_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream

module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_wr = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural FIFO contents and expected output order.
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  // Abstract accounting: reads accepted so far, reads accepted up to two
  // cycles back (visible now), and words popped.
  int acc_total = 0;
  int acc_old = 0;
  int pops = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [7:0] last_pop_d = 8'h00;

  always #5 clk = ~clk;

`ifdef FIFO_RD_STATS_EN
  logic [15:0] xfer_count, stall_count;
  logic [1:0]  xfer2, stall2;
  logic        rd2, v2;
  logic [7:0]  d2;

  fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_wr(fifo_wr),
    .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .xfer_count(xfer_count), .stall_count(stall_count));

  fifo_rd_stream #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_wr(fifo_wr),
    .fifo_dout(fifo_dout), .fifo_rd(rd2), .m_data(d2),
    .m_valid(v2), .m_ready(m_ready),
    .xfer_count(xfer2), .stall_count(stall2));
`else
  fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_wr(fifo_wr),
    .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready));
`endif

  task automatic reset_models();
    fq.delete();
    exp_q.delete();
    acc_total = 0;
    acc_old = 0;
    pops = 0;
    prev_stall = 1'b0;
    fifo_empty = 1'b1;
  endtask

  task automatic preload(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge. Drives inputs,
  // checks the stream against the abstract model, then advances the FIFO.
  task automatic cyc(input logic rdy, input logic wr,
                     output logic rd_o, output logic v_o, output logic [7:0] d_o,
                     output logic popd);
    logic [7:0] wd;
    logic       acc;
    logic       exp_rd;
    logic       exp_v;
    wd = 8'($urandom);
    m_ready = rdy;
    fifo_wr = wr;
    #1;
    rd_o = fifo_rd;
    v_o  = m_valid;
    d_o  = m_data;
    popd = v_o && rdy;

    exp_v = (acc_old - pops) > 0;
    n_vec++;
    if (v_o !== exp_v) begin
      n_err++;
      $display("FAIL m_valid: got %b want %b at %0t", v_o, exp_v, $time);
    end

    exp_rd = (fq.size() != 0) && ((acc_total - pops - (exp_v && rdy ? 1 : 0)) < 2);
    n_vec++;
    if (rd_o !== exp_rd) begin
      n_err++;
      $display("FAIL fifo_rd: got %b want %b at %0t", rd_o, exp_rd, $time);
    end

    if (prev_stall) begin
      n_vec++;
      if (v_o !== 1'b1 || d_o !== prev_d) begin
        n_err++;
        $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h at %0t", v_o, d_o, prev_d, $time);
      end
    end

    if (popd) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_extra: got %h want no beat at %0t", d_o, $time);
      end else begin
        if (d_o !== exp_q[0]) begin
          n_err++;
          $display("FAIL pop_data: got %h want %h at %0t", d_o, exp_q[0], $time);
        end
        void'(exp_q.pop_front());
      end
      last_pop_d = d_o;
    end

    acc = rd_o && (fq.size() != 0) && !wr;
    acc_old = acc_total;
    acc_total += acc ? 1 : 0;
    pops += popd ? 1 : 0;
    prev_stall = v_o && !rdy;
    prev_d = d_o;

    @(posedge clk);
    #1;
    if (acc) fifo_dout = fq.pop_front();
    if (wr) begin
      fq.push_back(wd);
      exp_q.push_back(wd);
    end
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
    fifo_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    reset_models();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic r, v, p;
    logic [7:0] d;
    rst = 1'b0;
    reset_models();
    preload(8'h11); preload(8'h22); preload(8'h33);
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (fifo_rd !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_hold: got rd=%b v=%b d=%h want 0 0 00", fifo_rd, m_valid, m_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, r, v, d, p);
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (fifo_rd !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async: got rd=%b v=%b d=%h want 0 0 00", fifo_rd, m_valid, m_data);
    end
    reset_models();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    logic r[6];
    logic v[6];
    logic [7:0] d[6];
    logic p;
    logic exp_r[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_v[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d[6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    preload(8'h11); preload(8'h22); preload(8'h33);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, r[i], v[i], d[i], p);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (r[i] !== exp_r[i] || v[i] !== exp_v[i] || (exp_v[i] && d[i] !== exp_d[i])) begin
        n_err++;
        $display("FAIL stream_c%0d: got rd=%b v=%b d=%h want rd=%b v=%b d=%h",
                 i, r[i], v[i], d[i], exp_r[i], exp_v[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic r, v, p;
    logic [7:0] d;
    int reads = 0;
    int npop = 0;
    preload(8'h11); preload(8'h22); preload(8'h33); preload(8'h44);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, r, v, d, p);
      reads += r ? 1 : 0;
      if (v) begin
        n_vec++;
        if (d !== 8'h11) begin
          n_err++;
          $display("FAIL bp_head: got %h want 11", d);
        end
      end
    end
    n_vec++;
    if (reads !== 2) begin
      n_err++;
      $display("FAIL bp_reads: got %0d want 2", reads);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, r, v, d, p);
      npop += p ? 1 : 0;
    end
    n_vec++;
    if (npop !== 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain: got %0d pops (%0d left) want 4 (0 left)", npop, exp_q.size());
    end
  endtask

  task automatic test_collision();
    logic r, v, p;
    logic [7:0] d;
    int npop = 0;
    preload(8'h11); preload(8'h22); preload(8'h33);
    cyc(1'b1, 1'b1, r, v, d, p);
    n_vec++;
    if (r !== 1'b1) begin
      n_err++;
      $display("FAIL coll_rd: got %b want 1", r);
    end
    cyc(1'b1, 1'b0, r, v, d, p);
    n_vec++;
    if (r !== 1'b1 || v !== 1'b0) begin
      n_err++;
      $display("FAIL coll_retry: got rd=%b v=%b want rd=1 v=0", r, v);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, r, v, d, p);
      npop += p ? 1 : 0;
    end
    n_vec++;
    if (npop !== 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL coll_drain: got %0d pops want 4", npop);
    end
  endtask

  task automatic test_reset_midstream();
    logic r, v, p;
    logic [7:0] d;
    logic [7:0] seen[$];
    preload(8'h11); preload(8'h22); preload(8'h33); preload(8'h44);
    repeat (3) cyc(1'b0, 1'b0, r, v, d, p);
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (m_valid !== 1'b0 || fifo_rd !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b rd=%b want 0 0", m_valid, fifo_rd);
    end
    reset_models();
    @(negedge clk);
    rst = 1'b1;
    preload(8'hA0); preload(8'hA1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, r, v, d, p);
      if (p) seen.push_back(d);
    end
    n_vec++;
    if (seen.size() != 2) begin
      n_err++;
      $display("FAIL mid_count: got %0d beats want 2", seen.size());
    end else if (seen[0] !== 8'hA0 || seen[1] !== 8'hA1) begin
      n_err++;
      $display("FAIL mid_data: got %h %h want a0 a1", seen[0], seen[1]);
    end
  endtask

  task automatic test_random();
    logic r, v, p;
    logic [7:0] d;
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, ($urandom % 2) == 0, r, v, d, p);
    for (int i = 0; i < 80; i++) cyc(1'b1, 1'b0, r, v, d, p);
    n_vec++;
    if (exp_q.size() != 0 || fq.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d words outstanding want 0", exp_q.size());
    end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    logic r, v, p;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) preload(8'(8'h50 + i));
    repeat (5) cyc(1'b0, 1'b0, r, v, d, p);
    repeat (10) cyc(1'b1, 1'b0, r, v, d, p);
    n_vec++;
    if (xfer_count !== 16'd5 || stall_count !== 16'd3) begin
      n_err++;
      $display("FAIL stats_cnt: got xfer=%0d stall=%0d want 5 3", xfer_count, stall_count);
    end
    do_reset();
    preload(8'h77);
    repeat (7) cyc(1'b0, 1'b0, r, v, d, p);
    n_vec++;
    if (stall2 !== 2'd3 || stall_count !== 16'd5) begin
      n_err++;
      $display("FAIL stats_sat: got stall2=%0d stall=%0d want 3 5", stall2, stall_count);
    end
    repeat (4) cyc(1'b1, 1'b0, r, v, d, p);
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_collision();
    test_reset_midstream();
    test_random();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
